pipeline_consumer: RTL and testbench

Downstream sink for the stallable valid/allow pipeline. It owns the pipeline's `out_allow` backpressure, buffers accepted beats in a small FIFO, and drains them at a fixed programmable rate. Drained beats are presented on a one-cycle strobe and folded into a running sum and beat count. It sits at the output end of the stallable adder pipeline and is used to exercise stall behaviour in simulation and on board.

---
 rtl/pipeline_consumer.sv | 105 ++++++++++
 tb/tb_pipeline_consumer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_consumer.sv
// Rate-limited sink for the stallable valid/allow pipeline: FIFO buffer, fixed-rate drain, running sum/count.
// Optional running parity of drained entries when PIPELINE_CONSUMER_PARITY_EN is defined.
module pipeline_consumer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int DRAIN_DIV = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               validin,
  input  logic [WIDTH-1:0]   datain,
  output logic               out_allow,
  output logic               drain_valid,
  output logic [WIDTH-1:0]   drain_data,
  output logic [WIDTH+7:0]   sum,
  output logic [15:0]        count,
  output logic               parity
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int SW = WIDTH + 8;
  localparam logic [OW-1:0] FULL     = OW'(DEPTH);
  localparam logic [7:0]    DIV_LAST = 8'(DRAIN_DIV - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [OW-1:0]    occ;
  logic [7:0]       div_cnt;
  logic             tick;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head;

  // Backpressure depends only on registered occupancy, never on validin.
  assign out_allow = !rst && (occ < FULL);
  assign tick      = (div_cnt == DIV_LAST);
  assign push      = validin && out_allow;
  assign pop       = tick && (occ != '0);
  assign head      = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage carries data only; validity lives in occ and the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= datain;
  end

  // Drain stage: registered strobe, data and accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_valid <= 1'b0;
      drain_data  <= '0;
      sum         <= '0;
      count       <= '0;
    end else begin
      drain_valid <= pop;
      if (pop) begin
        drain_data <= head;
        sum        <= sum + SW'(head);
        count      <= count + 16'd1;
      end
    end
  end

`ifdef PIPELINE_CONSUMER_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (pop) begin
      parity_q <= parity_q ^ (^head);
    end
  end

  assign parity = parity_q;
`else
  assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_consumer.sv
// Self-checking bench for pipeline_consumer: directed scenarios plus randomized traffic against a queue model.
module tb_pipeline_consumer;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 4;
  localparam int DRAIN_DIV = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             validin = 1'b0;
  logic [WIDTH-1:0] datain = '0;
  logic             out_allow;
  logic             drain_valid;
  logic [WIDTH-1:0] drain_data;
  logic [WIDTH+7:0] sum;
  logic [15:0]      count;
  logic             parity;

  pipeline_consumer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DRAIN_DIV(DRAIN_DIV)) dut (
    .clk(clk), .rst(rst), .validin(validin), .datain(datain),
    .out_allow(out_allow), .drain_valid(drain_valid), .drain_data(drain_data),
    .sum(sum), .count(count), .parity(parity)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a queue of buffered beats and the edge number since reset release.
  logic [WIDTH-1:0] q[$];
  int               edge_no;
  logic             dv_m;
  logic [WIDTH-1:0] dd_m;
  logic [15:0]      sum_m;
  logic [15:0]      count_m;
  logic             parity_m;

  logic accepted;
  logic saw_stall;
  int   pulses;
  int   pulse_edge;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    edge_no  = 0;
    dv_m     = 1'b0;
    dd_m     = '0;
    sum_m    = '0;
    count_m  = '0;
    parity_m = 1'b0;
    pulses   = 0;
    pulse_edge = -1;
  endtask

  task automatic check_outputs();
    chk("drain_valid", 32'(drain_valid), 32'(dv_m));
    chk("drain_data",  32'(drain_data),  32'(dd_m));
    chk("sum",         32'(sum),         32'(sum_m));
    chk("count",       32'(count),       32'(count_m));
`ifdef PIPELINE_CONSUMER_PARITY_EN
    chk("parity",      32'(parity),      32'(parity_m));
`else
    chk("parity",      32'(parity),      32'(0));
`endif
  endtask

  // One clock edge: predict from the pre-edge inputs, then compare after the edge.
  task automatic step();
    logic             push_m;
    logic             pop_m;
    logic [WIDTH-1:0] din_s;
    logic [WIDTH-1:0] e;
    push_m = validin && (q.size() < DEPTH);
    din_s  = datain;
    chk("out_allow", 32'(out_allow), 32'(q.size() < DEPTH));
    if (validin && !out_allow) saw_stall = 1'b1;
    @(posedge clk);
    #1;
    edge_no++;
    pop_m = ((edge_no % DRAIN_DIV) == 0) && (q.size() > 0);
    if (pop_m) begin
      e        = q.pop_front();
      dv_m     = 1'b1;
      dd_m     = e;
      sum_m    = sum_m + 16'(e);
      count_m  = count_m + 16'd1;
      parity_m = parity_m ^ (^e);
    end else begin
      dv_m = 1'b0;
    end
    if (push_m) q.push_back(din_s);
    accepted = push_m;
    if (drain_valid) begin
      pulses++;
      pulse_edge = edge_no;
    end
    check_outputs();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    validin = 1'b0;
    model_clear();
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      chk("rst_allow", 32'(out_allow), 32'(0));
      check_outputs();
    end
    rst = 1'b0;
    #1;
    chk("allow_after_rst", 32'(out_allow), 32'(1));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    model_clear();
    chk("pulse_allow", 32'(out_allow), 32'(0));
    check_outputs();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int   cyc;
    logic [WIDTH-1:0] nxt;
    model_clear();
    saw_stall = 1'b0;
    accepted  = 1'b0;

    // Reset held for two cycles
    do_reset(2);

    // Single beat of 0x05 before edge 1
    validin = 1'b1;
    datain  = 8'h05;
    step();
    validin = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("single_pulses", 32'(pulses), 32'(1));
    chk("single_edge",   32'(pulse_edge), 32'(3));
    chk("single_sum",    32'(sum), 32'(5));
    chk("single_count",  32'(count), 32'(1));

    // Backpressure: continuous offer, data advances only when accepted
    do_reset(1);
    saw_stall = 1'b0;
    nxt = 8'd1;
    validin = 1'b1;
    datain = nxt;
    for (int i = 0; i < 45; i++) begin
      step();
      if (accepted) begin
        nxt++;
        datain = nxt;
      end
    end
    validin = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("bp_stalled", 32'(saw_stall), 32'(1));
    chk("bp_count", 32'(count), 32'(nxt - 8'd1));
    chk("bp_last",  32'(drain_data), 32'(nxt - 8'd1));

    // Sum wrap with 258 beats of 0xFF
    do_reset(1);
    begin
      int sent;
      sent = 0;
      cyc = 0;
      datain = 8'hFF;
      while (count_m < 16'd258 && cyc < 2000) begin
        validin = (sent < 258);
        step();
        if (accepted) sent++;
        cyc++;
      end
      validin = 1'b0;
      chk("wrap_timeout", 32'(cyc < 2000), 32'(1));
      chk("wrap_count", 32'(count), 32'(258));
      chk("wrap_sum",   32'(sum), 32'(16'h00FE));
    end

    // Reset mid-operation with three entries buffered
    do_reset(1);
    validin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      datain = 8'(8'h10 + i);
      step();
    end
    validin = 1'b0;
    pulse_reset();
    chk("mid_sum",   32'(sum), 32'(0));
    chk("mid_count", 32'(count), 32'(0));
    validin = 1'b1;
    datain  = 8'h2A;
    step();
    validin = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("mid_pulses", 32'(pulses), 32'(1));
    chk("mid_edge",   32'(pulse_edge), 32'(3));
    chk("mid_data",   32'(drain_data), 32'(8'h2A));

    // Parity: drain 0x01 then 0x03
    do_reset(1);
    validin = 1'b1;
    datain  = 8'h01;
    step();
    datain  = 8'h03;
    step();
    validin = 1'b0;
    for (int i = 0; i < 8; i++) step();
`ifdef PIPELINE_CONSUMER_PARITY_EN
    chk("parity_13", 32'(parity), 32'(1));
`else
    chk("parity_13", 32'(parity), 32'(0));
`endif

    // Randomized traffic with occasional resets
    do_reset(1);
    for (int i = 0; i < 2500; i++) begin
      validin = ($urandom_range(0, 3) != 0);
      datain  = 8'($urandom);
      step();
      if ($urandom_range(0, 299) == 0) pulse_reset();
    end
    validin = 1'b0;
    for (int i = 0; i < 20; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
